// File: rtl/ntt_addr_gen.sv
// NTT address generator: butterfly operand pairs, twiddle index and stage number
// for every stage of a forward or inverse transform over N = 2**LOGN points.
module ntt_addr_gen #(
    parameter int LOGN      = 7,
    parameter int STAGE_GAP = 2,
    parameter int SW        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            inv,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-1:0] tw_idx,
    output logic [SW-1:0]   stage,
    output logic            last_in_stage,
    output logic            inv_o,
    output logic            done
);

    localparam int HW = LOGN - 1;
    localparam int TW = $clog2(LOGN + 1);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] t;        // stage of the next beat to load
    logic [HW-1:0] i;        // beat index of the next beat to load
    logic          wait_hs;  // whole stage loaded, waiting for its last handshake
    logic [GW-1:0] gap_cnt;
    logic          hs, load, accept;

    logic [TW-1:0]   lg, rl;
    logic [LOGN-1:0] ii, len, g, j, a_nxt, b_nxt, tw_nxt;

    assign hs   = out_valid & out_ready;
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Beat arithmetic for (t, i); rl = LOGN-1-lg selects the twiddle group base.
    always_comb begin
        lg     = inv_o ? t : TW'(LOGN - 1) - t;
        rl     = TW'(LOGN - 1) - lg;
        ii     = {1'b0, i};
        len    = LOGN'(1) << lg;
        g      = ii >> lg;
        j      = ii & (len - 1'b1);
        a_nxt  = (g << (lg + 1'b1)) | j;
        b_nxt  = a_nxt + len;
        tw_nxt = (LOGN'(1) << rl) + g;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (!wait_hs) begin
                    load = !out_valid || out_ready;
                end else if (hs) begin
                    if (t == TW'(LOGN))    state_nxt = FIN;
                    else if (STAGE_GAP == 0) load = 1'b1;
                    else                   state_nxt = GAP;
                end
            end
            GAP: begin
                if (STAGE_GAP == 0 || gap_cnt == GW'(STAGE_GAP - 1)) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            t             <= '0;
            i             <= '0;
            wait_hs       <= 1'b0;
            gap_cnt       <= '0;
            out_valid     <= 1'b0;
            addr_a        <= '0;
            addr_b        <= '0;
            tw_idx        <= '0;
            stage         <= '0;
            last_in_stage <= 1'b0;
            inv_o         <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (accept) begin
                inv_o   <= inv;
                t       <= '0;
                i       <= '0;
                wait_hs <= 1'b0;
            end
            if (load) begin
                out_valid     <= 1'b1;
                addr_a        <= a_nxt;
                addr_b        <= b_nxt;
                tw_idx        <= tw_nxt;
                stage         <= SW'(t);
                last_in_stage <= &i;
                // Counters run one beat ahead of the output register.
                if (&i) begin
                    i       <= '0;
                    t       <= t + 1'b1;
                    wait_hs <= 1'b1;
                end else begin
                    i       <= i + 1'b1;
                    wait_hs <= 1'b0;
                end
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
